// File: rtl/vm_pkg.sv
// Shared types and default prices for the vending controller.
package vm_pkg;
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SELECT   = 4'd1,
    COLLECT  = 4'd2,
    DISPENSE = 4'd3
  } state_t;

  localparam logic [3:0] DEF_PRICE0 = 4'd4;
  localparam logic [3:0] DEF_PRICE1 = 4'd6;
  localparam logic [3:0] DEF_PRICE2 = 4'd8;
  localparam logic [3:0] DEF_PRICE3 = 4'd10;

  function automatic logic [3:0] price_of(input logic [1:0] item);
    case (item)
      2'd0:    return DEF_PRICE0;
      2'd1:    return DEF_PRICE1;
      2'd2:    return DEF_PRICE2;
      default: return DEF_PRICE3;
    endcase
  endfunction
endpackage

// File: rtl/vm_credit_unit.sv
// Credit datapath: add coin, compare to price, saturate credit, compute change.
// Purely combinational, zero latency; no backpressure.
module vm_credit_unit (
  input  logic [3:0] curr,
  input  logic [3:0] coin,
  input  logic [3:0] price,
  output logic       paid,
  output logic [3:0] curr_next,
  output logic [3:0] change
);
  logic [4:0] sum;

  assign sum       = {1'b0, curr} + {1'b0, coin};
  assign paid      = (sum >= {1'b0, price});
  assign curr_next = sum[4] ? 4'hF : sum[3:0];
  // True change is at most 14, so the low nibble alone gives the exact result.
  assign change    = sum[3:0] - price;
endmodule

// File: rtl/final_vending_machine.sv
// Single-purchase vending FSM; e pulses the cycle after the completing coin is sampled.
// Standalone block: no handshake, start=0 aborts and refunds.
module final_vending_machine
  import vm_pkg::*;
#(
  parameter logic [3:0] PRICE0 = DEF_PRICE0,
  parameter logic [3:0] PRICE1 = DEF_PRICE1,
  parameter logic [3:0] PRICE2 = DEF_PRICE2,
  parameter logic [3:0] PRICE3 = DEF_PRICE3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] data,
  output logic       e,
  output logic [3:0] curr,
  output logic [3:0] state,
  output logic [3:0] money,
  output logic [1:0] item_number,
  output logic [3:0] temp,
  output logic       ld_money
);
  state_t     state_q, state_d;
  logic [3:0] curr_d, money_d, price;
  logic [1:0] item_d;
  logic       paid;
  logic [3:0] curr_sum, change;

  always_comb begin
    case (item_number)
      2'd0:    price = PRICE0;
      2'd1:    price = PRICE1;
      2'd2:    price = PRICE2;
      default: price = PRICE3;
    endcase
  end

  vm_credit_unit u_credit (
    .curr      (curr),
    .coin      (data),
    .price     (price),
    .paid      (paid),
    .curr_next (curr_sum),
    .change    (change)
  );

  always_comb begin
    state_d = IDLE;
    curr_d  = curr;
    money_d = money;
    item_d  = item_number;
    case (state_q)
      IDLE: begin
        curr_d  = 4'd0;
        state_d = start ? SELECT : IDLE;
      end
      SELECT: begin
        if (start) begin
          item_d  = data[1:0];
          money_d = 4'd0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (!start) begin
          money_d = curr;
          curr_d  = 4'd0;
        end else if (paid) begin
          curr_d  = curr_sum;
          money_d = change;
          state_d = DISPENSE;
        end else begin
          curr_d  = curr_sum;
          state_d = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      curr        <= 4'd0;
      money       <= 4'd0;
      item_number <= 2'd0;
      temp        <= 4'd0;
    end else begin
      state_q     <= state_d;
      curr        <= curr_d;
      money       <= money_d;
      item_number <= item_d;
      temp        <= data;
    end
  end

  assign state    = state_q;
  assign e        = (state_q == DISPENSE);
  assign ld_money = (state_q == COLLECT) && (data != 4'd0) && start;
endmodule

// File: tb/tb_final_vending_machine.sv
// Scenario bench for final_vending_machine; dispense results go through a scoreboard queue.
module tb_final_vending_machine;
  import vm_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] data;
  logic       e, ld_money;
  logic [3:0] curr, state, money, temp;
  logic [1:0] item_number;

  typedef struct {
    logic [3:0] curr;
    logic [3:0] money;
  } exp_t;
  exp_t sb[$];
  exp_t ex;

  int checks = 0;
  int failures = 0;
  int e_count = 0;
  int e_base;

  final_vending_machine dut (
    .clk(clk), .rst(rst), .start(start), .data(data), .e(e), .curr(curr),
    .state(state), .money(money), .item_number(item_number), .temp(temp),
    .ld_money(ld_money)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (e === 1'b1) e_count <= e_count + 1;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From IDLE with start=1, arrive in COLLECT with the item latched.
  task automatic go_collect(input logic [1:0] item);
    start = 1'b1;
    data  = {2'b00, item};
    tick();
    tick();
    data  = 4'd0;
    #1;
  endtask

  // Drive a completing coin, push the expected result, pop it when e appears.
  task automatic pay_last(input string name, input logic [3:0] coin);
    exp_t want;
    logic [3:0] sum5;
    sum5 = 4'd0;
    data = coin;
    want.curr  = ((curr + coin) > 15) ? 4'hF : 4'(curr + coin);
    want.money = 4'(curr + coin - price_of(item_number));
    sum5 = want.curr;
    sb.push_back(want);
    tick();
    data = 4'd0;
    checks++;
    if (e !== 1'b1 || state !== 4'd3) begin
      failures++;
      $display("FAIL %s_latency e=%0b state=%0d want e=1 state=3 (curr=%0d)", name, e, state, sum5);
    end else begin
      ex = sb.pop_front();
      checks++;
      if (curr !== ex.curr || money !== ex.money) begin
        failures++;
        $display("FAIL %s_result curr=%0d money=%0d want curr=%0d money=%0d", name, curr, money, ex.curr, ex.money);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data = 4'd0;
    tick(); tick();
    checks++;
    if (state !== 4'd0 || curr !== 4'd0 || money !== 4'd0 || item_number !== 2'd0 ||
        temp !== 4'd0 || e !== 1'b0 || ld_money !== 1'b0) begin
      failures++;
      $display("FAIL reset_state state=%0d curr=%0d money=%0d item=%0d temp=%0d e=%0b ld=%0b want all 0",
               state, curr, money, item_number, temp, e, ld_money);
    end
    data = 4'd5; start = 1'b1;
    tick();
    checks++;
    if (temp !== 4'd0 || state !== 4'd0) begin
      failures++;
      $display("FAIL reset_priority temp=%0d state=%0d want 0 0", temp, state);
    end
    data = 4'd0;
  endtask

  task automatic test_to_collect();
    rst = 1'b0; start = 1'b1; data = 4'd0;
    tick();
    checks++;
    if (state !== 4'd1) begin
      failures++;
      $display("FAIL enter_select state=%0d want 1", state);
    end
    tick();
    checks++;
    if (state !== 4'd2 || item_number !== 2'd0 || curr !== 4'd0 || e !== 1'b0) begin
      failures++;
      $display("FAIL enter_collect state=%0d item=%0d curr=%0d e=%0b want 2 0 0 0", state, item_number, curr, e);
    end
  endtask

  task automatic test_item0();
    data = 4'd4;
    #1;
    checks++;
    if (ld_money !== 1'b1) begin
      failures++;
      $display("FAIL item0_ld_money got=%0b want 1", ld_money);
    end
    pay_last("item0", 4'd4);
    tick();
    checks++;
    if (state !== 4'd0 || e !== 1'b0) begin
      failures++;
      $display("FAIL item0_idle state=%0d e=%0b want 0 0", state, e);
    end
  endtask

  task automatic test_item1();
    logic [3:0] coins [3];
    logic [3:0] want [3];
    coins[0] = 4'd2; coins[1] = 4'd1; coins[2] = 4'd2;
    want[0]  = 4'd2; want[1]  = 4'd3; want[2]  = 4'd5;
    go_collect(2'd1);
    checks++;
    if (item_number !== 2'd1 || money !== 4'd0 || state !== 4'd2) begin
      failures++;
      $display("FAIL item1_select item=%0d money=%0d state=%0d want 1 0 2", item_number, money, state);
    end
    for (int i = 0; i < 3; i++) begin
      data = coins[i];
      tick();
      checks++;
      if (curr !== want[i] || state !== 4'd2) begin
        failures++;
        $display("FAIL item1_coin%0d curr=%0d state=%0d want %0d 2", i, curr, state, want[i]);
      end
    end
    data = 4'd0;
    #1;
    checks++;
    if (ld_money !== 1'b0) begin
      failures++;
      $display("FAIL item1_zero_ld got=%0b want 0", ld_money);
    end
    tick();
    checks++;
    if (curr !== 4'd5) begin
      failures++;
      $display("FAIL item1_zero_coin curr=%0d want 5", curr);
    end
    pay_last("item1", 4'd2);
    tick();
  endtask

  task automatic test_saturate();
    go_collect(2'd3);
    data = 4'd9;
    tick();
    checks++;
    if (curr !== 4'd9) begin
      failures++;
      $display("FAIL sat_pre curr=%0d want 9", curr);
    end
    e_base = e_count;
    pay_last("item3_sat", 4'd15);
    tick(); tick();
    checks++;
    if (e_count - e_base !== 1) begin
      failures++;
      $display("FAIL sat_pulses got=%0d want 1", e_count - e_base);
    end
  endtask

  task automatic test_abort();
    start = 1'b0; tick(); // settle in IDLE
    go_collect(2'd2);
    data = 4'd5;
    tick();
    e_base = e_count;
    start = 1'b0; data = 4'd3;
    #1;
    checks++;
    if (ld_money !== 1'b0) begin
      failures++;
      $display("FAIL abort_ld got=%0b want 0", ld_money);
    end
    tick();
    checks++;
    if (state !== 4'd0 || money !== 4'd5 || curr !== 4'd0 || e !== 1'b0) begin
      failures++;
      $display("FAIL abort_refund state=%0d money=%0d curr=%0d e=%0b want 0 5 0 0", state, money, curr, e);
    end
    tick();
    checks++;
    if (e_count !== e_base || temp !== 4'd3) begin
      failures++;
      $display("FAIL abort_no_dispense pulses=%0d temp=%0d want 0 3", e_count - e_base, temp);
    end
  endtask

  task automatic test_reset_mid();
    go_collect(2'd0);
    data = 4'd3;
    tick();
    checks++;
    if (curr !== 4'd3 || state !== 4'd2) begin
      failures++;
      $display("FAIL rstmid_pre curr=%0d state=%0d want 3 2", curr, state);
    end
    rst = 1'b1; data = 4'd6;
    tick();
    checks++;
    if (state !== 4'd0 || curr !== 4'd0 || money !== 4'd0 || item_number !== 2'd0 ||
        temp !== 4'd0 || e !== 1'b0 || ld_money !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_clear state=%0d curr=%0d money=%0d item=%0d temp=%0d e=%0b ld=%0b want all 0",
               state, curr, money, item_number, temp, e, ld_money);
    end
    rst = 1'b0; start = 1'b0; data = 4'd9;
    tick();
    checks++;
    if (temp !== 4'd9 || state !== 4'd0) begin
      failures++;
      $display("FAIL temp_track1 temp=%0d state=%0d want 9 0", temp, state);
    end
    data = 4'd2;
    tick();
    checks++;
    if (temp !== 4'd2) begin
      failures++;
      $display("FAIL temp_track2 temp=%0d want 2", temp);
    end
  endtask

  task automatic test_back_to_back();
    go_collect(2'd0);
    pay_last("b2b", 4'd7);
    tick();
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL b2b_idle state=%0d want 0", state);
    end
    tick();
    checks++;
    if (state !== 4'd1) begin
      failures++;
      $display("FAIL b2b_reselect state=%0d want 1", state);
    end
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL sb_drained left=%0d want 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data = 4'd0;
    test_reset();
    test_to_collect();
    test_item0();
    test_item1();
    test_saturate();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
